gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//   Registered up/down counter for the binary-to-gray path. Holds a WIDTH-bit binary
//   count and its Gray-coded image, updated on the same edge.
//   It is the upstream source that steps the converter stage through every code in
//   order, one bit change per step. Supports load, direction, terminal-count pulse and
//   wrap or saturate at the ends.
// PARAMETERS
//   WIDTH      3   counter width in bits (>=2)
//   WRAP_MODE  1   1: wrap MAX<->0; 0: saturate, hold at MAX (up) or 0 (down)
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous reset, active low
//   en        in   1      count enable, one step per enabled cycle
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      load load_val this cycle (overrides en)
//   load_val  in   WIDTH  binary value to load
//   bin_out   out  WIDTH  registered binary count
//   gray_out  out  WIDTH  registered Gray code of bin_out, = bin ^ (bin >> 1)
//   term      out  1      1-cycle pulse on a step taken at the terminal value
//   chk_err   out  1      sticky Gray-step error (present only with GRAY_CNT_CHK_EN)
// BEHAVIOUR
//   - All outputs change only on the clk rising edge.
//   - Reset: rst_n low at an edge sets bin_out=0, gray_out=0, term=0, chk_err=0.
//     Reset overrides load and en, including mid-count.
//   - Priority per edge: reset > load > en > hold.
//   - load=1: bin_out<=load_val, gray_out<=bin2gray(load_val), term<=0.
//     en and up_dn are ignored that cycle.
//   - en=1, load=0, up: next = bin_out+1, computed modulo 2^WIDTH.
//   - en=1, load=0, down: next = bin_out-1, computed modulo 2^WIDTH.
//   - gray_out is computed from next, never from the old value.
//     bin_out and gray_out are therefore always coherent in the same cycle.
//     Latency is one edge from en to the new value on both outputs.
//   - Terminal value: MAX=2^WIDTH-1 when counting up, 0 when counting down.
//   - term=1 for exactly the cycle after an edge where en=1, load=0 and bin_out was
//     at the terminal for the current direction; otherwise term=0.
//   - WRAP_MODE=1 at terminal: MAX->0 (up), 0->MAX (down); term pulses.
//   - WRAP_MODE=0 at terminal: count holds, gray_out holds; term still pulses every
//     enabled cycle at the terminal.
//   - en=0, load=0: hold all state; term<=0.
//   - up_dn may change on any cycle; it takes effect on the next enabled edge.
//   - No state machine: state is bin_out, plus chk_err when the checker is compiled in.
// CONFIGURATION
//   GRAY_CNT_CHK_EN defined:
//     - Adds port chk_err and the step checker.
//     - On every counting step (en=1, load=0, value actually changed), require
//       popcount(gray_next ^ gray_out)==1.
//     - If not, chk_err<=1 and stays 1 until reset.
//     - Load and saturate-hold cycles are not checked.
//   GRAY_CNT_CHK_EN not defined:
//     - No chk_err port and no checker logic.
//     - Counter behaviour is otherwise identical.
// STRUCTURE
//   - Package gray_pkg holds the shared pieces:
//     - functions bin2gray, gray2bin and onehot_chk (popcount==1);
//     - localparam DEF_WIDTH=3.
//     The converter stage and its bench share this package.
//   - One sub-module, gray_step_chk: prev/next Gray in, sticky err out.
//     Instantiated only under GRAY_CNT_CHK_EN.
// TESTING (WIDTH=3 unless stated)
//   1. Reset then en=1, up_dn=1 for 9 cycles:
//      bin 0..7,0; gray 000,001,011,010,110,111,101,100,000; term only after 7->0.
//   2. load=1, load_val=3'b101 with en=1: next cycle bin=101, gray=111, term=0;
//      then en=1, up_dn=0 gives 100/110.
//   3. Down from 0, WRAP_MODE=1: bin 0->7, gray 000->100, term=1 one cycle.
//      Same with WRAP_MODE=0: bin holds 0 and term=1 on each enabled cycle.
//   4. rst_n=0 for one edge while counting at bin=6: next cycle bin=0, gray=0, term=0;
//      counting resumes 1,2,...
//   5. Toggle en 1,0,1,0 and flip up_dn mid-run: holds when en=0.
//      Every step changes exactly one gray_out bit; chk_err stays 0.
//   6. With GRAY_CNT_CHK_EN, force a corrupt next gray via bench hook:
//      chk_err=1 next cycle and stays 1 until rst_n=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared pieces for the Gray counter and the binary-to-Gray converter stage.
//   DEF_WIDTH  : default counter width
//   MAX_W      : widest value the helper functions accept; callers zero-extend
//   bin2gray   : binary -> Gray
//   gray2bin   : Gray -> binary
//   onehot_chk : 1 when exactly one bit is set
package gray_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int MAX_W     = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic onehot_chk(input logic [MAX_W-1:0] x);
    return ($countones(x) == 1);
  endfunction
endpackage

// File: rtl/gray_counter_if.sv
// Control/data bundle of the Gray counter.
//   en, up_dn, load, load_val : controls from the driver (master)
//   bin_out, gray_out, term   : registered counter outputs (slave)
//   chk_err, chk_inj          : sticky step error and a debug hook that corrupts
//                               the Gray value seen by the checker; both exist only
//                               when GRAY_CNT_CHK_EN is defined.
interface gray_counter_if
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             term;
`ifdef GRAY_CNT_CHK_EN
  logic             chk_err;
  logic             chk_inj;

  modport master (output en, up_dn, load, load_val, chk_inj,
                  input  bin_out, gray_out, term, chk_err);
  modport slave  (input  en, up_dn, load, load_val, chk_inj,
                  output bin_out, gray_out, term, chk_err);
`else
  modport master (output en, up_dn, load, load_val,
                  input  bin_out, gray_out, term);
  modport slave  (input  en, up_dn, load, load_val,
                  output bin_out, gray_out, term);
`endif
endinterface

// File: rtl/gray_counter_step_chk.sv
// gray_step_chk: flags any counting step whose Gray value changes by other than
// exactly one bit. The error is sticky until synchronous reset.
//   clk, rst_n : clock, synchronous active-low reset
//   step_i     : a real counting step happens on this edge
//   prev_i     : Gray value currently held
//   next_i     : Gray value about to be registered
//   err_o      : sticky error
module gray_step_chk
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] next_i,
  output logic             err_o
);
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (step_i && !onehot_chk(MAX_W'(prev_i ^ next_i))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down binary counter with a coherent Gray image.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : gray_counter_if slave (en, up_dn, load, load_val -> bin_out,
//                gray_out, term [, chk_err])
// Parameters: WIDTH (>=2), WRAP_MODE (1 wrap at the ends, 0 saturate).
// Optional: define GRAY_CNT_CHK_EN to add the Gray single-step checker and chk_err.
// Priority per edge: reset > load > en > hold.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit WRAP_MODE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             term_q, term_d;
  logic             at_term;
  logic             step;

  assign at_term = bus.up_dn ? (bin_q == MAX) : (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    term_d = 1'b0;
    step   = 1'b0;
    if (bus.load) begin
      bin_d  = bus.load_val;
      gray_d = WIDTH'(bin2gray(MAX_W'(bus.load_val)));
    end else if (bus.en) begin
      term_d = at_term;
      // Saturating mode holds at the end; term still pulses.
      if (WRAP_MODE || !at_term) begin
        bin_d  = bus.up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        // Gray comes from the new value so both outputs move together.
        gray_d = WIDTH'(bin2gray(MAX_W'(bin_d)));
        step   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      term_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      term_q <= term_d;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.term     = term_q;

`ifdef GRAY_CNT_CHK_EN
  // chk_inj flips bit 0 of what the checker sees, never the counter itself.
  gray_step_chk #(.WIDTH(WIDTH)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (step),
    .prev_i (gray_q),
    .next_i (gray_d ^ WIDTH'(bus.chk_inj)),
    .err_o  (bus.chk_err)
  );
`else
  logic unused_step;
  assign unused_step = step;
`endif
endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB;
  gray_counter_if #(.WIDTH(3)) ifA ();
  gray_counter_if #(.WIDTH(3)) ifB ();

  gray_counter #(.WIDTH(3), .WRAP_MODE(1'b1)) dutA (.clk(clk), .rst_n(rstA), .bus(ifA));
  gray_counter #(.WIDTH(3), .WRAP_MODE(1'b0)) dutB (.clk(clk), .rst_n(rstB), .bus(ifB));

  typedef struct {
    logic       sel;   // 0: wrap DUT, 1: saturate DUT
    logic       rst_n, en, up, load, inj;
    logic [2:0] lv;
    logic [2:0] eb, eg;
    logic       et, ee; // expected term, expected chk_err
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0, errors = 0, vidx = 0;

  function automatic vec_t mk(logic sel, logic r, logic en, logic up, logic ld,
                              logic [2:0] lv, logic [2:0] eb, logic [2:0] eg,
                              logic et, logic inj = 1'b0, logic ee = 1'b0);
    vec_t v;
    v.sel = sel; v.rst_n = r; v.en = en; v.up = up; v.load = ld; v.inj = inj;
    v.lv = lv; v.eb = eb; v.eg = eg; v.et = et; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d act=%b exp=%b", nm, idx, act, exp);
    end
  endtask

  task automatic idle_all();
    rstA = 1'b1; rstB = 1'b1;
    ifA.en = 0; ifA.up_dn = 1; ifA.load = 0; ifA.load_val = '0;
    ifB.en = 0; ifB.up_dn = 1; ifB.load = 0; ifB.load_val = '0;
`ifdef GRAY_CNT_CHK_EN
    ifA.chk_inj = 0; ifB.chk_inj = 0;
`endif
  endtask

  // Drive one vector, push its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    idle_all();
    if (!v.sel) begin
      rstA = v.rst_n; ifA.en = v.en; ifA.up_dn = v.up; ifA.load = v.load; ifA.load_val = v.lv;
`ifdef GRAY_CNT_CHK_EN
      ifA.chk_inj = v.inj;
`endif
    end else begin
      rstB = v.rst_n; ifB.en = v.en; ifB.up_dn = v.up; ifB.load = v.load; ifB.load_val = v.lv;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!e.sel) begin
      chk("binA", vidx, ifA.bin_out, e.eb);
      chk("grayA", vidx, ifA.gray_out, e.eg);
      chk("termA", vidx, {2'b0, ifA.term}, {2'b0, e.et});
`ifdef GRAY_CNT_CHK_EN
      chk("chk_errA", vidx, {2'b0, ifA.chk_err}, {2'b0, e.ee});
`endif
    end else begin
      chk("binB", vidx, ifB.bin_out, e.eb);
      chk("grayB", vidx, ifB.gray_out, e.eg);
      chk("termB", vidx, {2'b0, ifB.term}, {2'b0, e.et});
    end
    vidx++;
  endtask

  initial begin
    logic [2:0] rb, pg, g;
    logic       at;
    idle_all();

    // sel rst en up ld lv  bin     gray    term
    // Reset both, then count up through the wrap.
    tbl.push_back(mk(0, 0, 1, 1, 1, 3'd5, 3'd0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 3'd0, 3'd0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd2, 3'b011, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd3, 3'b010, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd4, 3'b110, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd5, 3'b111, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd6, 3'b101, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd7, 3'b100, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd0, 3'b000, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0));
    // Load overrides en; then count down.
    tbl.push_back(mk(0, 1, 1, 1, 1, 3'd5, 3'd5, 3'b111, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 3'd4, 3'b110, 0));
    // Load at terminal with en=1 gives no term; then down wrap 0->7, then hold.
    tbl.push_back(mk(0, 1, 1, 0, 1, 3'd0, 3'd0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 3'd7, 3'b100, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3'd0, 3'd7, 3'b100, 0));
    // Reset mid-count at 6, then resume.
    tbl.push_back(mk(0, 1, 0, 1, 1, 3'd6, 3'd6, 3'b101, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 3'd3, 3'd0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd0, 3'd2, 3'b011, 0));
    // Saturating DUT: hold at 0 going down, at 7 going up; term on each enabled cycle.
    tbl.push_back(mk(1, 1, 1, 0, 0, 3'd0, 3'd0, 3'b000, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 3'd0, 3'd0, 3'b000, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 3'd6, 3'd6, 3'b101, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 3'd0, 3'd7, 3'b100, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 3'd0, 3'd7, 3'b100, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 3'd0, 3'd7, 3'b100, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 3'd0, 3'd7, 3'b100, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 3'd0, 3'd6, 3'b101, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Mixed en/direction run against a small reference model on the wrap DUT.
    apply(mk(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'b000, 0));
    rb = 3'd0;
    pg = 3'b000;
    for (int i = 0; i < 40; i++) begin
      logic en, up;
      en = (i % 4 < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      up = (i < 13) || (i >= 27);
      at = en && (up ? (rb == 3'd7) : (rb == 3'd0));
      if (en) rb = up ? rb + 3'd1 : rb - 3'd1;
      g = rb ^ (rb >> 1);
      apply(mk(0, 1, en, up, 0, 3'd0, rb, g, at));
      // Each step should move exactly one Gray bit; a hold moves none.
      checks++;
      if ($countones(ifA.gray_out ^ pg) != (en ? 1 : 0)) begin
        errors++;
        $display("FAIL gray_step i=%0d act=%b prev=%b", i, ifA.gray_out, pg);
      end
      pg = ifA.gray_out;
    end

`ifdef GRAY_CNT_CHK_EN
    // Corrupt the checked Gray on one step: error sets and sticks until reset.
    apply(mk(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'b000, 0));
    apply(mk(0, 1, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0, 1'b0, 1'b0));
    apply(mk(0, 1, 1, 1, 0, 3'd0, 3'd2, 3'b011, 0, 1'b1, 1'b1));
    apply(mk(0, 1, 1, 1, 0, 3'd0, 3'd3, 3'b010, 0, 1'b0, 1'b1));
    apply(mk(0, 1, 0, 1, 1, 3'd4, 3'd4, 3'b110, 0, 1'b0, 1'b1));
    apply(mk(0, 0, 1, 1, 0, 3'd0, 3'd0, 3'b000, 0, 1'b0, 1'b0));
    apply(mk(0, 1, 1, 1, 0, 3'd0, 3'd1, 3'b001, 0, 1'b0, 1'b0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
